// File: rtl/intl_trip_ctrl.sv
// Interlock trip controller: masks and debounces the monitor's fault word, latches trips,
// records the first fault, gates PWM enable and runs the operator clear handshake.
module intl_trip_ctrl #(
    parameter int DB_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [15:0]     i_intl_state,
    input  logic [15:0]     i_intl_mask,
    input  logic [DB_W-1:0] i_debounce,
    input  logic            i_intl_rst,
    input  logic            i_pwm_run_req,
    output logic            o_pwm_en,
    output logic [15:0]     o_intl_latch,
    output logic [4:0]      o_first_fault,
    output logic            o_intl_active,
    output logic            o_rst_ack,
    output logic            o_rst_nack,
    output logic [15:0]     o_trip_cnt
);

    typedef enum logic [1:0] {NORMAL, TRIP, CLEAR, REARM} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     masked;
    logic [15:0]     qual;
    logic [3:0]      low_idx;
    logic [DB_W-1:0] cnt [16];
    logic [15:0]     trip_cnt;
    logic            trip_evt;
    logic            ack_set;
    logic            nack_set;

    // A bit qualifies once its masked fault has persisted i_debounce cycles past its first cycle.
    always_comb begin
        masked = i_intl_state & i_intl_mask;
        qual   = '0;
        for (int i = 0; i < 16; i++) begin
            qual[i] = masked[i] && (cnt[i] >= i_debounce);
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (qual[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= REARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: if (|qual) state_nxt = TRIP;
            TRIP:   if (i_intl_rst && (masked == '0)) state_nxt = CLEAR;
            CLEAR:  state_nxt = REARM;
            REARM: begin
                if (|qual) begin
                    state_nxt = TRIP;
                end else if (!i_pwm_run_req) begin
                    state_nxt = NORMAL;
                end
            end
            default: state_nxt = REARM;
        endcase
    end

    always_comb begin
        trip_evt = ((state == NORMAL) || (state == REARM)) && (|qual);
        ack_set  = (state == TRIP) && i_intl_rst && (masked == '0);
        nack_set = (state == TRIP) && i_intl_rst && (masked != '0);
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 16; i++) begin
            if (i_rst || (state == CLEAR) || !masked[i]) begin
                cnt[i] <= '0;
            end else if (!(&cnt[i])) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // The latch keeps accumulating while tripped; only the CLEAR cycle wipes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_intl_latch  <= '0;
            o_first_fault <= '0;
            o_pwm_en      <= 1'b0;
            o_rst_ack     <= 1'b0;
            o_rst_nack    <= 1'b0;
            trip_cnt      <= '0;
        end else begin
            o_pwm_en   <= (state == NORMAL) && !(|qual) && i_pwm_run_req;
            o_rst_ack  <= ack_set;
            o_rst_nack <= nack_set;
            if (trip_evt && (trip_cnt != 16'hFFFF)) begin
                trip_cnt <= trip_cnt + 16'd1;
            end
            if (state == CLEAR) begin
                o_intl_latch  <= '0;
                o_first_fault <= '0;
            end else begin
                o_intl_latch <= o_intl_latch | qual;
                if (!o_first_fault[4] && (|qual)) begin
                    o_first_fault <= {1'b1, low_idx};
                end
            end
        end
    end

    assign o_trip_cnt    = trip_cnt;
    assign o_intl_active = |o_intl_latch;

endmodule
